// File: rtl/cas_pkg.sv
// ---------------------------------------------------------------------------
// cas_pkg
// Shared definitions for the CAS sorting network stages.
//   ADDRW_DEF   : default index width carried alongside each value
//   WL_DEF      : default value width (IEEE-754 single, handled as raw bits)
//   cas_entry_t : one (index, value) pair as it travels between stages
//   clog2       : elaboration-time ceiling log2 for sizing pointers/counters
// ---------------------------------------------------------------------------
package cas_pkg;

    localparam int ADDRW_DEF = 10;
    localparam int WL_DEF    = 32;

    // Index sits in the upper bits so a packed entry sorts like {index, value}
    // when viewed as a flat vector by downstream stages.
    typedef struct packed {
        logic [ADDRW_DEF-1:0] index;
        logic [WL_DEF-1:0]    value;
    } cas_entry_t;

    // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cas_dualwr_regfile.sv
// ---------------------------------------------------------------------------
// cas_dualwr_regfile
// DEPTH-entry storage array for the pair serializer. Two write ports that
// always target consecutive slots (waddr_i and waddr_i+1, wrapping), and one
// asynchronous read port. Contents are deliberately not reset: validity is
// tracked entirely by the pointers and occupancy counter in the parent.
//   clk       : write clock, rising edge
//   we_a_i    : write wdata_a_i to slot waddr_i
//   we_b_i    : write wdata_b_i to slot waddr_i+1 (wraps modulo DEPTH)
//   waddr_i   : base write address
//   wdata_a_i : data for the base slot
//   wdata_b_i : data for the following slot
//   raddr_i   : read address
//   rdata_o   : combinational read data of slot raddr_i
// ---------------------------------------------------------------------------
module cas_dualwr_regfile
    import cas_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF,
    parameter int WL    = WL_DEF,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH),
    localparam int EW   = ADDRW + WL
) (
    input  logic          clk,
    input  logic          we_a_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_a_i,
    input  logic [EW-1:0] wdata_b_i,
    input  logic [AW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] waddr_b_s;

    // Second port address; natural binary wrap keeps it inside the array.
    assign waddr_b_s = waddr_i + {{(AW-1){1'b0}}, 1'b1};

    // Storage update; the two ports never collide because their addresses differ by one.
    always_ff @(posedge clk) begin
        if (we_a_i) begin
            mem_q[waddr_i] <= wdata_a_i;
        end
        if (we_b_i) begin
            mem_q[waddr_b_s] <= wdata_b_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cas_pair_serializer.sv
// ---------------------------------------------------------------------------
// cas_pair_serializer
// Collects up to two (index, value) entries per cycle from the two-lane CAS
// element into a small circular FIFO and replays them as one valid/ready
// stream: arrival-cycle order first, lane 1 ahead of lane 2 within a cycle.
// The CAS enable is only raised when two free slots are guaranteed, so the
// upstream never has to know how many of its lanes are valid.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   clr          : synchronous flush; discards any write/read in that cycle
//   in_valid1/2  : lane entry valid (CAS outvalid1/2)
//   in_index1/2  : lane index
//   in_value1/2  : lane value
//   upstream_ena : CAS enable; high means this cycle's inputs are consumed
//   out_valid    : output entry available
//   out_ready    : downstream accepts the output entry
//   out_index    : output index (zero while out_valid is low)
//   out_value    : output value (zero while out_valid is low)
//   count        : current FIFO occupancy
// ---------------------------------------------------------------------------
module cas_pair_serializer
    import cas_pkg::*;
#(
    parameter int ADDRW  = ADDRW_DEF,
    parameter int WL     = WL_DEF,
    parameter int DEPTH  = 8,
    localparam int CNTW  = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid1,
    input  logic [ADDRW-1:0] in_index1,
    input  logic [WL-1:0]    in_value1,
    input  logic             in_valid2,
    input  logic [ADDRW-1:0] in_index2,
    input  logic [WL-1:0]    in_value2,
    output logic             upstream_ena,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADDRW-1:0] out_index,
    output logic [WL-1:0]    out_value,
    output logic [CNTW-1:0]  count
);

    localparam int AW = clog2(DEPTH);
    localparam int EW = ADDRW + WL;

    // Highest occupancy that still leaves room for a full pair.
    localparam logic [CNTW-1:0] ENA_MAX = CNTW'(DEPTH - 2);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    logic            ena_q,    ena_d;
    logic            valid_q,  valid_d;

    // ---------------------------------------------------------------------
    // Per-cycle transfer decisions
    // ---------------------------------------------------------------------
    logic            we1_s, we2_s;
    logic            we_a_s, we_b_s;
    logic [1:0]      nwr_s;
    logic            rd_s;
    logic [EW-1:0]   lane1_s, lane2_s;
    logic [EW-1:0]   wdata_a_s;
    logic [EW-1:0]   rdata_s;

    assign lane1_s = {in_index1, in_value1};
    assign lane2_s = {in_index2, in_value2};

    // The enable is a register, so a lane write depends only on state and clr.
    assign we1_s = in_valid1 & ena_q & ~clr;
    assign we2_s = in_valid2 & ena_q & ~clr;

    // Port A takes whichever lane comes first; port B is used only for pairs,
    // which is what keeps a lone lane-2 entry from leaving a hole.
    assign we_a_s = we1_s | we2_s;
    assign we_b_s = we1_s & we2_s;
    assign nwr_s  = {1'b0, we1_s} + {1'b0, we2_s};

    // Reading only when valid makes out_ready harmless on an empty FIFO.
    assign rd_s = valid_q & out_ready & ~clr;

    // Port A data select: lane 1 when it writes, otherwise lane 2 alone.
    always_comb begin
        wdata_a_s = lane1_s;
        if (we1_s) begin
            wdata_a_s = lane1_s;
        end else begin
            wdata_a_s = lane2_s;
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    cas_dualwr_regfile #(
        .ADDRW (ADDRW),
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk       (clk),
        .we_a_i    (we_a_s),
        .we_b_i    (we_b_s),
        .waddr_i   (wr_ptr_q),
        .wdata_a_i (wdata_a_s),
        .wdata_b_i (lane2_s),
        .raddr_i   (rd_ptr_q),
        .rdata_o   (rdata_s)
    );

    // ---------------------------------------------------------------------
    // Next-state: clr wins over every write and read of the same cycle
    // ---------------------------------------------------------------------
    // Pointer, occupancy and flag next-state computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CNTW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(nwr_s);
            rd_ptr_d = rd_ptr_q + AW'(rd_s);
            count_d  = count_q + CNTW'(nwr_s) - CNTW'(rd_s);
        end
        // Flags are registered copies of functions of the next occupancy,
        // so they equal the same functions of count_q one cycle later.
        // The enable ignores a same-cycle read, which keeps it conservative
        // and free of any path from out_ready.
        ena_d   = (count_d <= ENA_MAX);
        valid_d = (count_d != {CNTW{1'b0}});
    end

    // State registers; reset leaves the enable high so the CAS may start at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CNTW{1'b0}};
            ena_q    <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ena_q    <= ena_d;
            valid_q  <= valid_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign upstream_ena = ena_q;
    assign out_valid    = valid_q;
    assign count        = count_q;

    // Head entry gated by valid so stale storage never shows on the bus;
    // the gate is a register, so reset clears the bus immediately.
    always_comb begin
        out_index = {ADDRW{1'b0}};
        out_value = {WL{1'b0}};
        if (valid_q) begin
            out_index = rdata_s[EW-1:WL];
            out_value = rdata_s[WL-1:0];
        end else begin
            out_index = {ADDRW{1'b0}};
            out_value = {WL{1'b0}};
        end
    end

endmodule
